// File: rtl/shift_cmd_pkg.sv
// Shared definitions for the shift command sequencer: op encoding (same
// encoding as the shift register's {s1,s0} mode selects), FSM states and
// default widths.
package shift_cmd_pkg;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_SER_W = 8;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_cmd_serializer.sv
// Serial source word for the sequencer. A load can shift in the same cycle,
// because the first serial bit of a command goes straight from the command
// word to the output register; the stored word then already holds the bit
// that comes next at o_lo (shift-right) or o_hi (shift-left). Zero fill, so a
// word that runs dry keeps feeding 0.
module shift_cmd_serializer
  import shift_cmd_pkg::*;
#(
  parameter int SER_W = DEF_SER_W
) (
  input  logic             CLK,
  input  logic             i_load,
  input  logic             i_shr,
  input  logic             i_shl,
  input  logic [SER_W-1:0] i_d,
  output logic             o_lo,
  output logic             o_hi
);

  logic [SER_W-1:0] r_word;

  // Load (optionally pre-shifted) or shift the serial word with zero fill.
  always_ff @(posedge CLK) begin
    if (i_load) begin
      if (i_shr)      r_word <= i_d >> 1;
      else if (i_shl) r_word <= i_d << 1;
      else            r_word <= i_d;
    end else if (i_shr) begin
      r_word <= r_word >> 1;
    end else if (i_shl) begin
      r_word <= r_word << 1;
    end
  end

  assign o_lo = r_word[0];
  assign o_hi = r_word[SER_W-1];

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer for the 3-bit universal shift register. Accepts
// HOLD/SHR/SHL/LOAD commands over valid/ready, drives the mode selects,
// serial inputs and parallel-load bus cycle by cycle, then pulses done.
// Every output is a register loaded from the next-state logic, so the first
// RUN cycle appears the cycle after the handshake edge.
// Optional build macro SHIFT_CMD_ABORT_EN adds an abort input that cuts a
// running command short and goes straight to DONE.
module shift_cmd_sequencer
  import shift_cmd_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SER_W = DEF_SER_W
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [SER_W-1:0] cmd_ser,
  input  logic [WIDTH-1:0] cmd_par,
`ifdef SHIFT_CMD_ABORT_EN
  input  logic             abort,
`endif
  output logic             s1,
  output logic             s0,
  output logic             MSB_in,
  output logic             LSB_in,
  output logic [WIDTH-1:0] I_par,
  output logic             busy,
  output logic             done
);

  state_t           r_state, w_nxt_state;
  logic [1:0]       r_op, w_nxt_op;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;

  logic             r_ready, w_nxt_ready;
  logic [1:0]       r_s, w_nxt_s;
  logic             r_msb, w_nxt_msb;
  logic             r_lsb, w_nxt_lsb;
  logic [WIDTH-1:0] r_par, w_nxt_par;
  logic             r_busy, w_nxt_busy;
  logic             r_done, w_nxt_done;

  logic             w_hs;
  logic             w_abort;
  logic             w_ser_load, w_ser_shr, w_ser_shl;
  logic             w_ser_lo, w_ser_hi;

`ifdef SHIFT_CMD_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_hs = cmd_valid & r_ready;

  shift_cmd_serializer #(
    .SER_W (SER_W)
  ) u_ser (
    .CLK    (CLK),
    .i_load (w_ser_load),
    .i_shr  (w_ser_shr),
    .i_shl  (w_ser_shl),
    .i_d    (cmd_ser),
    .o_lo   (w_ser_lo),
    .o_hi   (w_ser_hi)
  );

  // Next state plus the output values the shift register sees next cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_op    = r_op;
    w_nxt_cnt   = r_cnt;
    w_nxt_ready = 1'b0;
    w_nxt_s     = OP_HOLD;
    w_nxt_msb   = 1'b0;
    w_nxt_lsb   = 1'b0;
    w_nxt_par   = '0;
    w_nxt_busy  = 1'b0;
    w_nxt_done  = 1'b0;
    w_ser_load  = 1'b0;
    w_ser_shr   = 1'b0;
    w_ser_shl   = 1'b0;

    case (r_state)
      IDLE: begin
        w_nxt_ready = 1'b1;
        if (w_hs) begin
          w_nxt_ready = 1'b0;
          w_nxt_busy  = 1'b1;
          w_nxt_op    = cmd_op;
          w_ser_load  = 1'b1;
          // HOLD and zero-count shifts skip RUN entirely.
          w_nxt_state = DONE;
          w_nxt_done  = 1'b1;
          case (cmd_op)
            OP_LOAD: begin
              w_nxt_state = RUN;
              w_nxt_done  = 1'b0;
              w_nxt_s     = OP_LOAD;
              w_nxt_par   = cmd_par;
              w_nxt_cnt   = '0;
            end
            OP_SHR: begin
              if (cmd_cnt != '0) begin
                w_nxt_state = RUN;
                w_nxt_done  = 1'b0;
                w_nxt_s     = OP_SHR;
                w_nxt_msb   = cmd_ser[0];
                w_nxt_cnt   = cmd_cnt - CNT_W'(1);
                w_ser_shr   = 1'b1;
              end
            end
            OP_SHL: begin
              if (cmd_cnt != '0) begin
                w_nxt_state = RUN;
                w_nxt_done  = 1'b0;
                w_nxt_s     = OP_SHL;
                w_nxt_lsb   = cmd_ser[SER_W-1];
                w_nxt_cnt   = cmd_cnt - CNT_W'(1);
                w_ser_shl   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      RUN: begin
        w_nxt_busy = 1'b1;
        // r_cnt counts RUN cycles still to come after the current one.
        if (w_abort || (r_cnt == '0)) begin
          w_nxt_state = DONE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
          w_nxt_s   = r_op;
          if (r_op == OP_SHR) begin
            w_nxt_msb = w_ser_lo;
            w_ser_shr = 1'b1;
          end else if (r_op == OP_SHL) begin
            w_nxt_lsb = w_ser_hi;
            w_ser_shl = 1'b1;
          end
        end
      end

      DONE: begin
        w_nxt_state = IDLE;
        w_nxt_ready = 1'b1;
      end

      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  // State, command context and registered outputs; Clear aborts anything.
  always_ff @(posedge CLK) begin
    if (Clear) begin
      r_state <= IDLE;
      r_op    <= OP_HOLD;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_s     <= OP_HOLD;
      r_msb   <= 1'b0;
      r_lsb   <= 1'b0;
      r_par   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_op    <= w_nxt_op;
      r_cnt   <= w_nxt_cnt;
      r_ready <= w_nxt_ready;
      r_s     <= w_nxt_s;
      r_msb   <= w_nxt_msb;
      r_lsb   <= w_nxt_lsb;
      r_par   <= w_nxt_par;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
    end
  end

  assign cmd_ready = r_ready;
  assign s1        = r_s[1];
  assign s0        = r_s[0];
  assign MSB_in    = r_msb;
  assign LSB_in    = r_lsb;
  assign I_par     = r_par;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: directed cases plus random commands,
// compared cycle by cycle against a per-command expected trace.
module tb_shift_cmd_sequencer;

  logic       CLK = 1'b0;
  logic       Clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic [7:0] cmd_ser;
  logic [2:0] cmd_par;
  logic       abort;
  logic       s1, s0, MSB_in, LSB_in, busy, done;
  logic [2:0] I_par;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  logic [2:0] usr_q;

  always #5 CLK = ~CLK;

  shift_cmd_sequencer #(.WIDTH(3), .CNT_W(4), .SER_W(8)) dut (
    .CLK       (CLK),
    .Clear     (Clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_ser   (cmd_ser),
    .cmd_par   (cmd_par),
`ifdef SHIFT_CMD_ABORT_EN
    .abort     (abort),
`endif
    .s1        (s1),
    .s0        (s0),
    .MSB_in    (MSB_in),
    .LSB_in    (LSB_in),
    .I_par     (I_par),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [9:0] pk(input logic rdy, input logic [1:0] s,
                                    input logic m, input logic l,
                                    input logic [2:0] p, input logic b,
                                    input logic d);
    return {rdy, s, m, l, p, b, d};
  endfunction

  function automatic logic [9:0] obs();
    return {cmd_ready, s1, s0, MSB_in, LSB_in, I_par, busy, done};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [9:0] o, input logic [9:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Trace a command must produce, starting the cycle after its handshake:
  // its RUN cycles, one DONE cycle, then one IDLE cycle with cmd_ready high.
  task automatic build_exp(input logic [1:0] op, input logic [3:0] cnt,
                           input logic [7:0] ser, input logic [2:0] par);
    int n;
    logic m, l;
    exp_q.delete();
    if (op == 2'b11) n = 1;
    else if (op == 2'b01 || op == 2'b10) n = int'(cnt);
    else n = 0;
    for (int i = 0; i < n; i++) begin
      m = (op == 2'b01 && i < 8) ? ser[i] : 1'b0;
      l = (op == 2'b10 && i < 8) ? ser[7-i] : 1'b0;
      exp_q.push_back(pk(1'b0, op, m, l, (op == 2'b11) ? par : 3'b000, 1'b1, 1'b0));
    end
    exp_q.push_back(pk(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1));
    exp_q.push_back(pk(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
  endtask

  // Downstream 3-bit universal shift register driven by the observed outputs.
  task automatic usr_step();
    case ({s1, s0})
      2'b01:   usr_q = {MSB_in, usr_q[2:1]};
      2'b10:   usr_q = {usr_q[1:0], LSB_in};
      2'b11:   usr_q = I_par;
      default: ;
    endcase
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    checks++;
    assert (cmd_ready === 1'b1) else begin
      errors++;
      $error("FAIL %s ready_timeout observed=%b expected=1", tag, cmd_ready);
    end
  endtask

  task automatic handshake(input logic [1:0] op, input logic [3:0] cnt,
                           input logic [7:0] ser, input logic [2:0] par);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_ser   = ser;
    cmd_par   = par;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_cnt   = 4'($urandom);
    cmd_ser   = 8'($urandom);
    cmd_par   = 3'($urandom);
    build_exp(op, cnt, ser, par);
  endtask

  // Full command; with noise, cmd_valid is waved while busy and must be ignored.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] cnt,
                         input logic [7:0] ser, input logic [2:0] par, input bit noise);
    wait_ready(tag);
    handshake(op, cnt, ser, par);
    for (int k = 0; k < exp_q.size(); k++) begin
      check(tag, obs(), exp_q[k]);
      usr_step();
      if (k < exp_q.size() - 1) begin
        if (noise) begin
          cmd_valid = 1'($urandom);
          cmd_op    = 2'($urandom);
          cmd_cnt   = 4'($urandom);
          cmd_ser   = 8'($urandom);
          cmd_par   = 3'($urandom);
        end
        tick();
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    Clear     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_cnt   = 4'd0;
    cmd_ser   = 8'd0;
    cmd_par   = 3'd0;
    abort     = 1'b0;
    usr_q     = 3'b000;

    // Reset
    tick();
    check("rst_c0", obs(), 10'b0);
    tick();
    check("rst_c1", obs(), 10'b0);
    Clear = 1'b0;
    tick();
    check("rst_rdy", obs(), pk(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));

    // Directed commands
    run_cmd("load101", 2'b11, 4'd0, 8'h00, 3'b101, 1'b0);
    usr_q = 3'b000;
    run_cmd("shr3", 2'b01, 4'd3, 8'b0000_0110, 3'b000, 1'b0);
    checks++;
    assert (usr_q === 3'b110) else begin
      errors++;
      $error("FAIL usr_after_shr3 observed=%b expected=110", usr_q);
    end
    run_cmd("shl10", 2'b10, 4'd10, 8'hC0, 3'b000, 1'b0);
    run_cmd("hold", 2'b00, 4'd7, 8'hFF, 3'b111, 1'b0);
    run_cmd("shr0", 2'b01, 4'd0, 8'hFF, 3'b111, 1'b0);
    run_cmd("shl0", 2'b10, 4'd0, 8'hFF, 3'b111, 1'b0);
    run_cmd("shr15", 2'b01, 4'd15, 8'hA5, 3'b010, 1'b1);

    // Clear during the 2nd RUN cycle of SHR cnt=5: no done
    wait_ready("clr_mid");
    handshake(2'b01, 4'd5, 8'h5B, 3'b000);
    check("clr_run1", obs(), exp_q[0]);
    tick();
    check("clr_run2", obs(), exp_q[1]);
    Clear = 1'b1;
    tick();
    check("clr_zero", obs(), 10'b0);
    Clear = 1'b0;
    tick();
    check("clr_rdy", obs(), pk(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));

`ifdef SHIFT_CMD_ABORT_EN
    // Abort at the same point: DONE next, then IDLE
    handshake(2'b01, 4'd5, 8'h5B, 3'b000);
    check("abt_run1", obs(), exp_q[0]);
    tick();
    check("abt_run2", obs(), exp_q[1]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abt_done", obs(), pk(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1));
    tick();
    check("abt_idle", obs(), pk(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    // abort held in IDLE and across DONE has no effect on a HOLD command
    abort = 1'b1;
    run_cmd("abt_hold", 2'b00, 4'd3, 8'h11, 3'b001, 1'b0);
    abort = 1'b0;
`endif

    // Random commands
    for (int r = 0; r < 24; r++) begin
      run_cmd("rand", 2'($urandom), 4'($urandom), 8'($urandom), 3'($urandom),
              1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the run wanders off.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
